msd_seq_extractor: RTL and testbench

- Sequential, parametrised successor to the combinational most-significant-decimal-digit block.
- Takes a WIDTH-bit one's-complement value and finds its sign and most significant decimal digit by repeated divide-by-10, one step per clock.
- Also reports the number of decimal digits in the value.
- Sits between register/ALU outputs and display or BCD formatting logic; start/done handshake.

---
 rtl/msd_seq_extractor_if.sv | 32 +++
 rtl/msd_seq_extractor.sv | 112 +++++++++++
 tb/tb_msd_seq_extractor.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msd_seq_extractor_if.sv
// Start/done bus for msd_seq_extractor; the lsd field exists only when
// MSD_LSD_EN is defined.
interface msd_seq_extractor_if #(
  parameter int WIDTH = 6
);
   logic             start;
   logic [WIDTH-1:0] in;
   logic             busy;
   logic             done;
   logic [4:0]       msd;
   logic [3:0]       ndigits;
   logic [1:0]       state_dbg;
`ifdef MSD_LSD_EN
   logic [3:0]       lsd;
`endif

   modport master (
      output start, in,
      input  busy, done, msd, ndigits, state_dbg
`ifdef MSD_LSD_EN
      , input lsd
`endif
   );

   modport slave (
      input  start, in,
      output busy, done, msd, ndigits, state_dbg
`ifdef MSD_LSD_EN
      , output lsd
`endif
   );
endinterface

// File: rtl/msd_seq_extractor.sv
// Sequential one's-complement MSD / digit-count extractor, one divide-by-10 per clock.
// Optional least-significant-digit output enabled by defining MSD_LSD_EN.
module msd_seq_extractor #(
  parameter int WIDTH = 6
) (
   input logic                clk,
   input logic                rst_n,
   msd_seq_extractor_if.slave bus
);
   localparam int MW = WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [MW-1:0] mag_q, mag_d;
   logic          sign_q, sign_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [4:0]    msd_q, msd_d;
   logic [3:0]    nd_q, nd_d;
`ifdef MSD_LSD_EN
   logic [3:0]    lsd_work_q, lsd_work_d;
   logic [3:0]    lsd_q, lsd_d;
`endif

   logic [MW-1:0] mag_in;
   logic [31:0]   mag_ext;

   assign mag_in  = bus.in[WIDTH-1] ? ~bus.in[MW-1:0] : bus.in[MW-1:0];
   assign mag_ext = 32'(mag_q);

   // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
   // done is a one-cycle pulse and msd/ndigits hold until the next completion.
   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      sign_d  = sign_q;
      cnt_d   = cnt_q;
      msd_d   = msd_q;
      nd_d    = nd_q;
`ifdef MSD_LSD_EN
      lsd_work_d = lsd_work_q;
      lsd_d      = lsd_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               state_d = S_RUN;
               mag_d   = mag_in;
               sign_d  = bus.in[WIDTH-1];
               cnt_d   = 4'd1;
`ifdef MSD_LSD_EN
               lsd_work_d = 4'(32'(mag_in) % 32'd10);
`endif
            end
         end
         S_RUN: begin
            if (mag_ext >= 32'd10) begin
               mag_d = MW'(mag_ext / 32'd10);
               cnt_d = cnt_q + 4'd1;
            end else begin
               msd_d   = {~sign_q, mag_ext[3:0]};
               nd_d    = cnt_q;
               state_d = S_DONE;
`ifdef MSD_LSD_EN
               lsd_d = lsd_work_q;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         cnt_q   <= 4'd0;
         msd_q   <= 5'd0;
         nd_q    <= 4'd0;
`ifdef MSD_LSD_EN
         lsd_work_q <= 4'd0;
         lsd_q      <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         cnt_q   <= cnt_d;
         msd_q   <= msd_d;
         nd_q    <= nd_d;
`ifdef MSD_LSD_EN
         lsd_work_q <= lsd_work_d;
         lsd_q      <= lsd_d;
`endif
      end
   end

   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.msd       = msd_q;
   assign bus.ndigits   = nd_q;
   assign bus.state_dbg = state_q;
`ifdef MSD_LSD_EN
   assign bus.lsd       = lsd_q;
`endif
endmodule

// File: tb/tb_msd_seq_extractor.sv
// Self-checking bench for msd_seq_extractor at WIDTH 6, 16 and 32 with a
// per-instance expected queue popped on each done pulse.
module tb_msd_seq_extractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // entry: {due_cycle[18:0], pos, digit[3:0], ndigits[3:0], lsd[3:0]}
  logic [31:0] exp6_q[$];
  logic [31:0] exp16_q[$];
  logic [31:0] exp32_q[$];
  logic [31:0] e6, e16, e32;
  int done6_cnt = 0;
  int done16_cnt = 0;
  int done32_cnt = 0;

  msd_seq_extractor_if #(.WIDTH(6))  if6();
  msd_seq_extractor_if #(.WIDTH(16)) if16();
  msd_seq_extractor_if #(.WIDTH(32)) if32();

  msd_seq_extractor #(.WIDTH(6))  dut6  (.clk(clk), .rst_n(rst_n), .bus(if6.slave));
  msd_seq_extractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  msd_seq_extractor #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  // Reference: digit count from powers of ten, leading digit by division.
  function automatic logic [31:0] model(input int width, input logic [31:0] val,
                                        input int unsigned now);
    longint unsigned mag, p, lim;
    int d;
    logic pos;
    logic [3:0] dig, l;
    logic [18:0] due;
    lim = (64'd1 << (width - 1)) - 64'd1;
    pos = ~val[width-1];
    if (pos) mag = 64'(val) & lim;
    else     mag = (~64'(val)) & lim;
    d = 1;
    p = 10;
    while (p <= mag) begin
      d++;
      p = p * 10;
    end
    dig = 4'(mag / (p / 10));
    l = 4'(mag % 10);
    due = 19'(now + 1 + d);
    return {due, pos, dig, 4'(d), l};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (if6.done === 1'b1) begin
      done6_cnt++;
      tests_run++;
      if (exp6_q.size() == 0) begin
        tests_failed++;
        $display("FAIL w6_unexpected_done cycle=%0d msd=%b", cyc, if6.msd);
      end else begin
        e6 = exp6_q.pop_front();
        if (19'(cyc) !== e6[31:13]) begin
          tests_failed++;
          $display("FAIL w6_latency got_cycle=%0d exp_cycle=%0d", cyc, e6[31:13]);
        end
        tests_run++;
        if (if6.msd !== e6[12:8]) begin
          tests_failed++;
          $display("FAIL w6_msd got=%b exp=%b", if6.msd, e6[12:8]);
        end
        tests_run++;
        if (if6.ndigits !== e6[7:4]) begin
          tests_failed++;
          $display("FAIL w6_ndigits got=%0d exp=%0d", if6.ndigits, e6[7:4]);
        end
`ifdef MSD_LSD_EN
        tests_run++;
        if (if6.lsd !== e6[3:0]) begin
          tests_failed++;
          $display("FAIL w6_lsd got=%0d exp=%0d", if6.lsd, e6[3:0]);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (if16.done === 1'b1) begin
      done16_cnt++;
      tests_run++;
      if (exp16_q.size() == 0) begin
        tests_failed++;
        $display("FAIL w16_unexpected_done cycle=%0d msd=%b", cyc, if16.msd);
      end else begin
        e16 = exp16_q.pop_front();
        if (19'(cyc) !== e16[31:13]) begin
          tests_failed++;
          $display("FAIL w16_latency got_cycle=%0d exp_cycle=%0d", cyc, e16[31:13]);
        end
        tests_run++;
        if (if16.msd !== e16[12:8]) begin
          tests_failed++;
          $display("FAIL w16_msd got=%b exp=%b", if16.msd, e16[12:8]);
        end
        tests_run++;
        if (if16.ndigits !== e16[7:4]) begin
          tests_failed++;
          $display("FAIL w16_ndigits got=%0d exp=%0d", if16.ndigits, e16[7:4]);
        end
`ifdef MSD_LSD_EN
        tests_run++;
        if (if16.lsd !== e16[3:0]) begin
          tests_failed++;
          $display("FAIL w16_lsd got=%0d exp=%0d", if16.lsd, e16[3:0]);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (if32.done === 1'b1) begin
      done32_cnt++;
      tests_run++;
      if (exp32_q.size() == 0) begin
        tests_failed++;
        $display("FAIL w32_unexpected_done cycle=%0d msd=%b", cyc, if32.msd);
      end else begin
        e32 = exp32_q.pop_front();
        if (19'(cyc) !== e32[31:13]) begin
          tests_failed++;
          $display("FAIL w32_latency got_cycle=%0d exp_cycle=%0d", cyc, e32[31:13]);
        end
        tests_run++;
        if (if32.msd !== e32[12:8]) begin
          tests_failed++;
          $display("FAIL w32_msd got=%b exp=%b", if32.msd, e32[12:8]);
        end
        tests_run++;
        if (if32.ndigits !== e32[7:4]) begin
          tests_failed++;
          $display("FAIL w32_ndigits got=%0d exp=%0d", if32.ndigits, e32[7:4]);
        end
`ifdef MSD_LSD_EN
        tests_run++;
        if (if32.lsd !== e32[3:0]) begin
          tests_failed++;
          $display("FAIL w32_lsd got=%0d exp=%0d", if32.lsd, e32[3:0]);
        end
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic go6(input logic [5:0] val);
    @(negedge clk);
    if6.start = 1'b1;
    if6.in = val;
    exp6_q.push_back(model(6, 32'(val), cyc));
    @(negedge clk);
    if6.start = 1'b0;
  endtask

  task automatic go16(input logic [15:0] val);
    @(negedge clk);
    if16.start = 1'b1;
    if16.in = val;
    exp16_q.push_back(model(16, 32'(val), cyc));
    @(negedge clk);
    if16.start = 1'b0;
  endtask

  task automatic go32(input logic [31:0] val);
    @(negedge clk);
    if32.start = 1'b1;
    if32.in = val;
    exp32_q.push_back(model(32, val, cyc));
    @(negedge clk);
    if32.start = 1'b0;
  endtask

  task automatic drain(input int which);
    int budget;
    int left;
    budget = 0;
    left = (which == 6) ? exp6_q.size() : (which == 16) ? exp16_q.size() : exp32_q.size();
    while (left != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
      left = (which == 6) ? exp6_q.size() : (which == 16) ? exp16_q.size() : exp32_q.size();
    end
    tests_run++;
    if (left != 0) begin
      tests_failed++;
      $display("FAIL w%0d_done_timeout pending=%0d required=0", which, left);
      if (which == 6) exp6_q.delete();
      else if (which == 16) exp16_q.delete();
      else exp32_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({if6.busy, if6.done, if6.msd, if6.ndigits} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_w6 got=%b exp=0", {if6.busy, if6.done, if6.msd, if6.ndigits});
    end
    tests_run++;
    if (if6.state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state got=%0d exp=0", if6.state_dbg);
    end
    tests_run++;
    if ({if16.busy, if16.done, if16.msd, if16.ndigits, if32.busy, if32.done, if32.msd, if32.ndigits} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_wide got=%b exp=0", {if16.msd, if32.msd});
    end
`ifdef MSD_LSD_EN
    tests_run++;
    if (if6.lsd !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_lsd got=%0d exp=0", if6.lsd);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    go6(6'd29);
    tests_run++;
    if (if6.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy_c1 got=%b exp=1", if6.busy);
    end
    @(negedge clk);
    tests_run++;
    if (if6.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy_c2 got=%b exp=1", if6.busy);
    end
    @(negedge clk);
    tests_run++;
    if (if6.busy !== 1'b0 || if6.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done_cycle busy=%b done=%b exp busy=0 done=1", if6.busy, if6.done);
    end
    drain(6);
    tests_run++;
    if (if6.msd !== 5'b1_0010 || if6.ndigits !== 4'd2) begin
      tests_failed++;
      $display("FAIL basic_29 msd=%b nd=%0d exp msd=10010 nd=2", if6.msd, if6.ndigits);
    end
`ifdef MSD_LSD_EN
    tests_run++;
    if (if6.lsd !== 4'd9) begin
      tests_failed++;
      $display("FAIL basic_lsd got=%0d exp=9", if6.lsd);
    end
`endif
  endtask

  task automatic test_negative;
    go6(6'b100000);
    drain(6);
    tests_run++;
    if (if6.msd !== 5'b0_0011 || if6.ndigits !== 4'd2) begin
      tests_failed++;
      $display("FAIL neg_31 msd=%b nd=%0d exp msd=00011 nd=2", if6.msd, if6.ndigits);
    end
    go6(6'b111111);
    drain(6);
    repeat (3) @(negedge clk);
    tests_run++;
    if (if6.msd !== 5'b0_0000 || if6.ndigits !== 4'd1) begin
      tests_failed++;
      $display("FAIL neg_zero_hold msd=%b nd=%0d exp msd=00000 nd=1", if6.msd, if6.ndigits);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    if6.start = 1'b1;
    if6.in = 6'd0;
    exp6_q.push_back(model(6, 32'd0, cyc));
    @(negedge clk);
    if6.in = 6'd7;
    @(negedge clk);
    exp6_q.push_back(model(6, 32'd7, cyc));
    @(negedge clk);
    if6.start = 1'b0;
    tests_run++;
    if (if6.busy !== 1'b1 || if6.msd !== 5'b1_0000) begin
      tests_failed++;
      $display("FAIL b2b_hold_during_run busy=%b msd=%b exp busy=1 msd=10000", if6.busy, if6.msd);
    end
    drain(6);
    tests_run++;
    if (if6.msd !== 5'b1_0111 || if6.ndigits !== 4'd1) begin
      tests_failed++;
      $display("FAIL b2b_7 msd=%b nd=%0d exp msd=10111 nd=1", if6.msd, if6.ndigits);
    end
  endtask

  task automatic test_busy_ignore;
    int d0;
    d0 = done6_cnt;
    @(negedge clk);
    if6.start = 1'b1;
    if6.in = 6'd25;
    exp6_q.push_back(model(6, 32'd25, cyc));
    @(negedge clk);
    if6.in = 6'd3;
    @(negedge clk);
    if6.start = 1'b0;
    drain(6);
    repeat (3) @(negedge clk);
    tests_run++;
    if (done6_cnt - d0 !== 1 || if6.msd !== 5'b1_0010) begin
      tests_failed++;
      $display("FAIL busy_ignore dones=%0d msd=%b exp dones=1 msd=10010", done6_cnt - d0, if6.msd);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      go6(6'($urandom_range(0, 63)));
      drain(6);
    end
    for (int i = 0; i < 6; i++) begin
      go16(16'($urandom_range(0, 65535)));
      drain(16);
      go32($urandom());
      drain(32);
    end
  endtask

  task automatic test_wide16;
    int d0;
    d0 = done16_cnt;
    go16(16'd32767);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp16_q.delete();
    tests_run++;
    if (if16.busy !== 1'b0 || if16.msd !== 5'd0 || if16.ndigits !== 4'd0) begin
      tests_failed++;
      $display("FAIL w16_midreset busy=%b msd=%b nd=%0d exp all 0", if16.busy, if16.msd, if16.ndigits);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (done16_cnt !== d0) begin
      tests_failed++;
      $display("FAIL w16_abort_done dones=%0d exp=0", done16_cnt - d0);
    end
    go16(16'd32767);
    drain(16);
    tests_run++;
    if (if16.msd !== 5'b1_0011 || if16.ndigits !== 4'd5) begin
      tests_failed++;
      $display("FAIL w16_max msd=%b nd=%0d exp msd=10011 nd=5", if16.msd, if16.ndigits);
    end
    go16(16'h8000);
    drain(16);
  endtask

  task automatic test_wide32;
    go32(32'h7FFF_FFFF);
    drain(32);
    tests_run++;
    if (if32.msd !== 5'b1_0010 || if32.ndigits !== 4'd10) begin
      tests_failed++;
      $display("FAIL w32_max msd=%b nd=%0d exp msd=10010 nd=10", if32.msd, if32.ndigits);
    end
    go32(32'hFFFF_FFFF);
    drain(32);
    go32(32'h8000_0009);
    drain(32);
  endtask

  initial begin
    if6.start = 1'b0;  if6.in = '0;
    if16.start = 1'b0; if16.in = '0;
    if32.start = 1'b0; if32.in = '0;
    test_reset;
    test_basic;
    test_negative;
    test_back_to_back;
    test_busy_ignore;
    test_wide16;
    test_wide32;
    test_random;
    repeat (4) @(negedge clk);
    tests_run++;
    if (exp6_q.size() + exp16_q.size() + exp32_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue_empty pending=%0d exp=0", exp6_q.size() + exp16_q.size() + exp32_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
